// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage running one handshaked data-bus transaction per request.
// Optional feature macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses trap instead of going to the bus.
module load_store_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            stall,
  output logic            done,
  output logic            misalign,
  output logic [XLEN-1:0] rdata_out,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [3:0]      bus_be,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_ack,
  input  logic [XLEN-1:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_e            state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [XLEN-1:0]   bus_addr_q, bus_addr_d;
  logic [3:0]        bus_be_q, bus_be_d;
  logic [XLEN-1:0]   bus_wdata_q, bus_wdata_d;
  logic              done_q, done_d;
  logic              misalign_q, misalign_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [1:0]        lane_q, lane_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;

  logic [1:0]        req_size_s;
  logic [1:0]        req_lane_s;
  logic [3:0]        req_be_s;
  logic [XLEN-1:0]   req_wdata_s;
  logic              req_misalign_s;

  // Select the byte/half at the given lane and sign- or zero-extend it.
  function automatic logic [XLEN-1:0] extend_load(
    input logic [XLEN-1:0] word,
    input logic [1:0]      lane,
    input logic [1:0]      size,
    input logic            uns
  );
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] res;
    sh = word >> {lane, 3'b000};
    case (size)
      SZ_BYTE: res = uns ? {24'h000000, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_HALF: res = uns ? {16'h0000, sh[15:0]}   : {{16{sh[15]}}, sh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  // Decode size, lane, byte enables, store lanes and misalignment of the presented request.
  always_comb begin
    req_size_s     = req_funct3[1] ? SZ_WORD : {1'b0, req_funct3[0]};
    req_lane_s     = 2'b00;
    req_be_s       = 4'b1111;
    req_wdata_s    = req_wdata;
    req_misalign_s = 1'b0;
    case (req_size_s)
      SZ_BYTE: begin
        req_lane_s  = req_addr[1:0];
        req_be_s    = 4'b0001 << req_addr[1:0];
        req_wdata_s = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        req_lane_s  = {req_addr[1], 1'b0};
        req_be_s    = 4'b0011 << {req_addr[1], 1'b0};
        req_wdata_s = {2{req_wdata[15:0]}};
      end
      default: begin
        req_lane_s  = 2'b00;
        req_be_s    = 4'b1111;
        req_wdata_s = req_wdata;
      end
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    if (req_size_s == SZ_HALF) begin
      req_misalign_s = req_addr[0];
    end else if (req_size_s == SZ_WORD) begin
      req_misalign_s = (req_addr[1:0] != 2'b00);
    end else begin
      req_misalign_s = 1'b0;
    end
`else
    req_misalign_s = 1'b0;
`endif
  end

  // Next-state and registered-output logic for the IDLE/REQ/DONE handshake.
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    lane_d      = lane_q;
    size_d      = size_q;
    uns_d       = uns_q;
    done_d      = 1'b0;
    misalign_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_misalign_s) begin
          done_d     = 1'b1;
          misalign_d = 1'b1;
          state_d    = DONE;
        end else if (req_valid) begin
          bus_req_d   = 1'b1;
          bus_we_d    = req_we;
          bus_addr_d  = {req_addr[XLEN-1:2], 2'b00};
          bus_be_d    = req_be_s;
          bus_wdata_d = req_wdata_s;
          lane_d      = req_lane_s;
          size_d      = req_size_s;
          uns_d       = req_funct3[2];
          state_d     = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        // The transaction completes even if req_valid was withdrawn meanwhile.
        if (bus_ack) begin
          bus_req_d = 1'b0;
          done_d    = 1'b1;
          state_d   = DONE;
          if (!bus_we_q) begin
            rdata_d = extend_load(bus_rdata, lane_q, size_q, uns_q);
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          state_d = REQ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        bus_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops bus_req immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= {XLEN{1'b0}};
      bus_be_q    <= 4'b0000;
      bus_wdata_q <= {XLEN{1'b0}};
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
      rdata_q     <= {XLEN{1'b0}};
      lane_q      <= 2'b00;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      done_q      <= done_d;
      misalign_q  <= misalign_d;
      rdata_q     <= rdata_d;
      lane_q      <= lane_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
    end
  end

  assign stall     = req_valid && (state_q != DONE);
  assign done      = done_q;
  assign misalign  = misalign_q;
  assign rdata_out = rdata_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed plan items plus random accesses against a byte-arithmetic model.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        done;
  logic        misalign;
  logic [31:0] rdata_out;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int          checks;
  int          failures;
  logic [31:0] model_rdata;

  load_store_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .done(done), .misalign(misalign), .rdata_out(rdata_out),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Access size in bytes from funct3: bit1 set means word, else bit0 picks half/byte.
  function automatic int size_of(input logic [2:0] f3);
    if (f3[1]) return 4;
    return f3[0] ? 2 : 1;
  endfunction

  function automatic int lane_of(input logic [31:0] addr, input int sz);
    int a;
    a = addr % 4;
    return a - (a % sz);
  endfunction

  function automatic bit is_misaligned(input logic [31:0] addr, input int sz);
`ifdef LSU_MISALIGN_TRAP_EN
    return ((addr % 4) % sz) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] wd, input int sz);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 4; i++) r = r | (((wd >> (8 * (i % sz))) & 32'hFF) << (8 * i));
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] rd, input int lane, input int sz, input bit uns);
    longint unsigned v;
    longint unsigned span;
    v = 64'(rd) >> (8 * lane);
    if (sz == 4) return rd;
    span = 64'd1 << (8 * sz);
    v = v % span;
    if (!uns && (v >= span / 2)) v = v - span;
    return v[31:0];
  endfunction

  // One full request; keep leaves req_valid high afterwards, drop withdraws it during REQ.
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] rd, input int waits,
                     input bit keep, input bit drop);
    int sz;
    int lane;
    sz   = size_of(f3);
    lane = lane_of(addr, sz);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    #1;
    chk("stall_accept", 32'(stall), 32'd1);
    @(posedge clk); #1;
    if (is_misaligned(addr, sz)) begin
      chk("mis_done", 32'(done), 32'd1);
      chk("mis_flag", 32'(misalign), 32'd1);
      chk("mis_noreq", 32'(bus_req), 32'd0);
      chk("mis_stall", 32'(stall), 32'd0);
      chk("mis_rdata", rdata_out, model_rdata);
    end else begin
      chk("req_on", 32'(bus_req), 32'd1);
      chk("req_we", 32'(bus_we), 32'(we));
      chk("req_addr", bus_addr, {addr[31:2], 2'b00});
      chk("req_be", 32'(bus_be), ((32'd1 << sz) - 32'd1) << lane);
      if (we) chk("req_wdata", bus_wdata, exp_wdata(wd, sz));
      chk("req_nodone", 32'(done), 32'd0);
      chk("req_stall", 32'(stall), 32'd1);
      if (drop) req_valid = 1'b0;
      for (int i = 0; i < waits; i++) begin
        @(posedge clk); #1;
        chk("wait_req_held", 32'(bus_req), 32'd1);
        chk("wait_addr_held", bus_addr, {addr[31:2], 2'b00});
        chk("wait_nodone", 32'(done), 32'd0);
        if (!drop) chk("wait_stall", 32'(stall), 32'd1);
      end
      bus_ack = 1'b1; bus_rdata = rd;
      @(posedge clk); #1;
      bus_ack = 1'b0; bus_rdata = $urandom;
      if (!we) model_rdata = exp_load(rd, lane, sz, f3[2]);
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_nomis", 32'(misalign), 32'd0);
      chk("done_req_off", 32'(bus_req), 32'd0);
      chk("done_stall", 32'(stall), 32'd0);
      chk("done_rdata", rdata_out, model_rdata);
    end
    req_valid = keep;
    @(posedge clk); #1;
    chk("after_nodone", 32'(done), 32'd0);
    chk("after_noreq", 32'(bus_req), 32'd0);
    chk("after_nomis", 32'(misalign), 32'd0);
    chk("after_rdata", rdata_out, model_rdata);
  endtask

  initial begin
    checks = 0; failures = 0; model_rdata = 32'd0;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_we", 32'(bus_we), 32'd0);
    chk("rst_be", 32'(bus_be), 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mis", 32'(misalign), 32'd0);
    chk("rst_rdata", rdata_out, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // bus_ack outside REQ must be ignored
    bus_ack = 1'b1;
    @(posedge clk); #1;
    chk("stray_ack_done", 32'(done), 32'd0);
    chk("stray_ack_req", 32'(bus_req), 32'd0);
    bus_ack = 1'b0;

    txn(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0, 1'b0);
    chk("lw_value", rdata_out, 32'hDEADBEEF);
    txn(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFF7F, 1, 1'b0, 1'b0);
    chk("lb_value", rdata_out, 32'hFFFFFF80);
    txn(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FFFF7F, 0, 1'b0, 1'b0);
    chk("lbu_value", rdata_out, 32'h00000080);
    txn(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h55555555, 3, 1'b0, 1'b0);
    chk("sh_keeps_rdata", rdata_out, 32'h00000080);
    txn(1'b0, 3'b010, 32'h102, 32'h0, 32'h0BADF00D, 0, 1'b0, 1'b0);
    txn(1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0, 2, 1'b0, 1'b1);
    txn(1'b0, 3'b010, 32'h400, 32'h0, 32'h11223344, 1, 1'b1, 1'b0);
    txn(1'b1, 3'b010, 32'h404, 32'h99887766, 32'h0, 0, 1'b0, 1'b0);

    // reset while a transaction is outstanding
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h500;
    @(posedge clk); #1;
    chk("prerst_req", 32'(bus_req), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_req", 32'(bus_req), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_rdata", rdata_out, 32'd0);
    model_rdata = 32'd0;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    bus_ack = 1'b1;
    @(posedge clk); #1;
    chk("postrst_done", 32'(done), 32'd0);
    chk("postrst_req", 32'(bus_req), 32'd0);
    bus_ack = 1'b0;
    txn(1'b0, 3'b101, 32'h502, 32'h0, 32'h8001ABCD, 1, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
          $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
    end
    req_valid = 1'b0;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
